// File: rtl/riscv_trap_ctrl.sv
// riscv_trap_ctrl: machine-mode trap sequencer.
// Arbitrates exception / MRET / interrupt entry, writes MEPC and MCAUSE
// through the CSR write port while stalling the pipeline, then redirects
// fetch to MTVEC (trap) or MEPC (MRET). Owns GIE and its saved copy PGIE.
//
// Ports:
//   clk_i, rst_i            core clock, async active-high reset
//   irq_i, mie_i            level interrupt lines and MIE CSR value
//   mtvec_i, mepc_i         current MTVEC / MEPC CSR values
//   exc_valid_i/cause/pc    exception pulse from execute
//   cur_pc_i                PC saved as MEPC on an interrupt
//   mret_i                  MRET retiring pulse
//   gie_wen_i, gie_wdata_i  software write of GIE
//   csr_we_o/waddr_o/wdata_o, csr_wready_i   CSR write port
//   stall_o                 pipeline freeze while sequencing
//   redirect_o, redirect_pc_o  one-cycle fetch redirect and target
//   gie_o                   current global interrupt enable

module riscv_trap_ctrl #(
    parameter int   MXLEN          = 32,
    parameter int   CSR_ADDR_WIDTH = 12,
    parameter int   NUM_IRQ        = 4,
    parameter logic GIE_RST        = 1'b0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_IRQ-1:0]        irq_i,
    input  logic [MXLEN-1:0]          mie_i,
    input  logic [MXLEN-1:0]          mtvec_i,
    input  logic [MXLEN-1:0]          mepc_i,
    input  logic                      exc_valid_i,
    input  logic [4:0]                exc_cause_i,
    input  logic [MXLEN-1:0]          exc_pc_i,
    input  logic [MXLEN-1:0]          cur_pc_i,
    input  logic                      mret_i,
    input  logic                      gie_wen_i,
    input  logic                      gie_wdata_i,
    output logic                      csr_we_o,
    output logic [CSR_ADDR_WIDTH-1:0] csr_waddr_o,
    output logic [MXLEN-1:0]          csr_wdata_o,
    input  logic                      csr_wready_i,
    output logic                      stall_o,
    output logic                      redirect_o,
    output logic [MXLEN-1:0]          redirect_pc_o,
    output logic                      gie_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_EPC   = 2'd1,
        WR_CAUSE = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MEPC   = CSR_ADDR_WIDTH'(12'h341);
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MCAUSE = CSR_ADDR_WIDTH'(12'h342);

    state_t             state_q, state_d;
    logic [MXLEN-1:0]   epc_q, cause_q, target_q;
    logic               gie_q, pgie_q;

    logic [NUM_IRQ-1:0] irq_hit;
    logic [7:0]         irq_code;
    logic               idle, take_exc, take_mret, take_irq;

    // Low address bits of the vector/epc and the MIE bits outside the
    // external-interrupt window are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{mie_i, mtvec_i[1:0], mepc_i[1:0]};

    // Event arbitration: exception > MRET > lowest-index pending interrupt.
    always_comb begin
        irq_hit   = irq_i & mie_i[16 +: NUM_IRQ];
        irq_code  = 8'd16;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (irq_hit[k]) irq_code = 8'(16 + k);
        end
        idle      = (state_q == IDLE);
        take_exc  = idle && exc_valid_i;
        take_mret = idle && !exc_valid_i && mret_i;
        take_irq  = idle && !exc_valid_i && !mret_i && gie_q && (|irq_hit);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (take_exc || take_irq) state_d = WR_EPC;
                else if (take_mret)       state_d = REDIRECT;
            end
            WR_EPC:   if (csr_wready_i) state_d = WR_CAUSE;
            WR_CAUSE: if (csr_wready_i) state_d = REDIRECT;
            REDIRECT: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            epc_q    <= '0;
            cause_q  <= '0;
            target_q <= '0;
            gie_q    <= GIE_RST;
            pgie_q   <= 1'b0;
        end else begin
            if (take_exc) begin
                epc_q   <= exc_pc_i;
                cause_q <= MXLEN'(exc_cause_i);
                pgie_q  <= gie_q;
                gie_q   <= 1'b0;
            end else if (take_mret) begin
                target_q <= {mepc_i[MXLEN-1:2], 2'b00};
                gie_q    <= pgie_q;
                pgie_q   <= 1'b1;
            end else if (take_irq) begin
                epc_q   <= cur_pc_i;
                cause_q <= {1'b1, (MXLEN-1)'(irq_code)};
                pgie_q  <= gie_q;
                gie_q   <= 1'b0;
            end else if (idle && gie_wen_i) begin
                // A coincident trap takes the branches above, so its
                // clear of GIE overrides the software write.
                gie_q <= gie_wdata_i;
            end
            if (state_q == WR_CAUSE && csr_wready_i) begin
                target_q <= {mtvec_i[MXLEN-1:2], 2'b00};
            end
        end
    end

    // Outputs depend only on state and latched registers, so an async
    // reset drops them immediately and no input reaches an output.
    always_comb begin
        csr_we_o      = 1'b0;
        csr_waddr_o   = '0;
        csr_wdata_o   = '0;
        redirect_o    = 1'b0;
        redirect_pc_o = '0;
        case (state_q)
            WR_EPC: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = ADDR_MEPC;
                csr_wdata_o = epc_q;
            end
            WR_CAUSE: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = ADDR_MCAUSE;
                csr_wdata_o = cause_q;
            end
            REDIRECT: begin
                redirect_o    = 1'b1;
                redirect_pc_o = target_q;
            end
            default: ;
        endcase
        stall_o = (state_q != IDLE);
        gie_o   = gie_q;
    end

endmodule

// File: tb/tb_riscv_trap_ctrl.sv
// tb_riscv_trap_ctrl: self-checking bench for riscv_trap_ctrl.
// Expected CSR writes and redirects are queued when stimulus is driven.

module tb_riscv_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [3:0]  irq_i;
    logic [31:0] mie_i, mtvec_i, mepc_i;
    logic        exc_valid_i;
    logic [4:0]  exc_cause_i;
    logic [31:0] exc_pc_i, cur_pc_i;
    logic        mret_i, gie_wen_i, gie_wdata_i;
    logic        csr_we_o;
    logic [11:0] csr_waddr_o;
    logic [31:0] csr_wdata_o;
    logic        csr_wready_i;
    logic        stall_o, redirect_o;
    logic [31:0] redirect_pc_o;
    logic        gie_o;

    always #5 clk = ~clk;

    riscv_trap_ctrl dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .irq_i         (irq_i),
        .mie_i         (mie_i),
        .mtvec_i       (mtvec_i),
        .mepc_i        (mepc_i),
        .exc_valid_i   (exc_valid_i),
        .exc_cause_i   (exc_cause_i),
        .exc_pc_i      (exc_pc_i),
        .cur_pc_i      (cur_pc_i),
        .mret_i        (mret_i),
        .gie_wen_i     (gie_wen_i),
        .gie_wdata_i   (gie_wdata_i),
        .csr_we_o      (csr_we_o),
        .csr_waddr_o   (csr_waddr_o),
        .csr_wdata_o   (csr_wdata_o),
        .csr_wready_i  (csr_wready_i),
        .stall_o       (stall_o),
        .redirect_o    (redirect_o),
        .redirect_pc_o (redirect_pc_o),
        .gie_o         (gie_o)
    );

    typedef struct {
        bit          is_redir;
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } ev_t;

    ev_t sb[$];
    int  errs   = 0;
    int  checks = 0;
    int  cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic exp_wr(logic [31:0] a, logic [31:0] d, int c);
        sb.push_back('{1'b0, a, d, c});
    endtask

    task automatic exp_redir(logic [31:0] d, int c);
        sb.push_back('{1'b1, 32'h0, d, c});
    endtask

    task automatic mon(bit r, logic [31:0] a, logic [31:0] d);
        ev_t e;
        chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("ev_kind", 32'(r), 32'(e.is_redir));
            chk("ev_addr", a, e.addr);
            chk("ev_data", d, e.data);
            chk("ev_cycle", 32'(cyc), 32'(e.cyc));
        end
    endtask

    always @(negedge clk) begin
        if (!rst_i) begin
            if (csr_we_o && csr_wready_i) mon(1'b0, {20'h0, csr_waddr_o}, csr_wdata_o);
            if (redirect_o)               mon(1'b1, 32'h0, redirect_pc_o);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_ev();
        exc_valid_i = 1'b0;
        mret_i      = 1'b0;
        irq_i       = 4'b0;
        gie_wen_i   = 1'b0;
    endtask

    int t;

    initial begin
        rst_i        = 1'b1;
        clr_ev();
        mie_i        = 32'h0;
        mtvec_i      = 32'h0000_0203;
        mepc_i       = 32'h0;
        exc_cause_i  = 5'd0;
        exc_pc_i     = 32'h0;
        cur_pc_i     = 32'h0;
        gie_wdata_i  = 1'b0;
        csr_wready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;

        chk("rst_we", 32'(csr_we_o), 32'd0);
        chk("rst_waddr", 32'(csr_waddr_o), 32'd0);
        chk("rst_wdata", csr_wdata_o, 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_redir", 32'(redirect_o), 32'd0);
        chk("rst_rpc", redirect_pc_o, 32'd0);
        chk("rst_gie", 32'(gie_o), 32'd0);

        // exception, zero-wait writes
        t = cyc;
        exp_wr(32'h341, 32'h100, t + 1);
        exp_wr(32'h342, 32'h2, t + 2);
        exp_redir(32'h200, t + 3);
        exc_valid_i = 1'b1; exc_cause_i = 5'd2; exc_pc_i = 32'h100;
        step(); clr_ev();
        for (int i = 0; i < 3; i++) begin
            chk("exc_stall", 32'(stall_o), 32'd1);
            step();
        end
        chk("exc_idle", 32'(stall_o), 32'd0);

        // interrupt masked by GIE=0
        mie_i = 32'h000A_0000; irq_i = 4'b1010; cur_pc_i = 32'h44;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("irq_off_stall", 32'(stall_o), 32'd0);
        end
        clr_ev();

        gie_wen_i = 1'b1; gie_wdata_i = 1'b1;
        step(); clr_ev();
        chk("gie_set", 32'(gie_o), 32'd1);

        // interrupt, lowest pending line 1 -> cause 17
        t = cyc;
        exp_wr(32'h341, 32'h44, t + 1);
        exp_wr(32'h342, 32'h8000_0011, t + 2);
        exp_redir(32'h200, t + 3);
        irq_i = 4'b1010;
        step(); clr_ev();
        chk("irq_gie", 32'(gie_o), 32'd0);
        chk("irq_stall", 32'(stall_o), 32'd1);
        repeat (3) step();
        chk("irq_idle", 32'(stall_o), 32'd0);

        // MRET restores GIE from PGIE
        mepc_i = 32'h103;
        t = cyc;
        exp_redir(32'h100, t + 1);
        mret_i = 1'b1;
        step(); clr_ev();
        chk("mret_gie", 32'(gie_o), 32'd1);
        chk("mret_stall", 32'(stall_o), 32'd1);
        step();
        chk("mret_idle", 32'(stall_o), 32'd0);

        // exception beats MRET and pending interrupt
        t = cyc;
        exp_wr(32'h341, 32'h300, t + 1);
        exp_wr(32'h342, 32'h5, t + 2);
        exp_redir(32'h200, t + 3);
        exc_valid_i = 1'b1; exc_cause_i = 5'd5; exc_pc_i = 32'h300;
        mret_i = 1'b1; irq_i = 4'b1010;
        step(); clr_ev();
        chk("sim_gie", 32'(gie_o), 32'd0);
        repeat (3) step();
        chk("sim_idle", 32'(stall_o), 32'd0);

        // back-pressure: three wait cycles in WR_EPC
        t = cyc;
        exp_wr(32'h341, 32'h400, t + 4);
        exp_wr(32'h342, 32'h7, t + 5);
        exp_redir(32'h200, t + 6);
        csr_wready_i = 1'b0;
        exc_valid_i = 1'b1; exc_cause_i = 5'd7; exc_pc_i = 32'h400;
        step(); clr_ev();
        for (int i = 0; i < 3; i++) begin
            chk("bp_we", 32'(csr_we_o), 32'd1);
            chk("bp_addr", 32'(csr_waddr_o), 32'h341);
            chk("bp_data", csr_wdata_o, 32'h400);
            step();
        end
        csr_wready_i = 1'b1;
        repeat (3) step();
        chk("bp_idle", 32'(stall_o), 32'd0);

        // reset in WR_CAUSE abandons the sequence
        t = cyc;
        exp_wr(32'h341, 32'h500, t + 1);
        exc_valid_i = 1'b1; exc_cause_i = 5'd3; exc_pc_i = 32'h500;
        step(); clr_ev();
        step();
        csr_wready_i = 1'b0;
        chk("pre_rst_addr", 32'(csr_waddr_o), 32'h342);
        #2 rst_i = 1'b1;
        #1;
        chk("arst_we", 32'(csr_we_o), 32'd0);
        chk("arst_waddr", 32'(csr_waddr_o), 32'd0);
        chk("arst_wdata", csr_wdata_o, 32'd0);
        chk("arst_stall", 32'(stall_o), 32'd0);
        chk("arst_redir", 32'(redirect_o), 32'd0);
        chk("arst_gie", 32'(gie_o), 32'd0);
        @(posedge clk);
        #1 rst_i = 1'b0;
        csr_wready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_redir", 32'(redirect_o), 32'd0);
            chk("post_rst_stall", 32'(stall_o), 32'd0);
        end

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
